// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the accumulator CPU sequencer and instruction controller:
// phase constants, opcode encodings and the sequencer state encoding.
package cpu_sequencer_pkg;

  localparam logic [2:0] Phase0 = 3'd0;
  localparam logic [2:0] Phase1 = 3'd1;
  localparam logic [2:0] Phase2 = 3'd2;
  localparam logic [2:0] Phase3 = 3'd3;
  localparam logic [2:0] Phase4 = 3'd4;
  localparam logic [2:0] Phase5 = 3'd5;
  localparam logic [2:0] Phase6 = 3'd6;
  localparam logic [2:0] Phase7 = 3'd7;

  // The controller asserts halt during this phase of an HLT instruction
  localparam logic [2:0] PhaseHaltChk = Phase4;
  localparam logic [2:0] PhaseLast    = Phase7;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StHalted = 3'd3,
    StLoad   = 3'd4,
    StDone   = 3'd5
  } seq_state_e;

  function automatic logic is_exec(seq_state_e s);
    return (s == StRun) || (s == StStep);
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Shared memory port selection between the CPU datapath and the loader port.
// Strobes are blocked during the loader completion cycle.
module mem_port_mux #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              i_ld_gnt,
  input  logic              i_strobe_block,
  input  logic [AWIDTH-1:0] i_cpu_addr,
  input  logic [DWIDTH-1:0] i_cpu_wdata,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  input  logic              i_ld_we,
  input  logic [AWIDTH-1:0] i_ld_addr,
  input  logic [DWIDTH-1:0] i_ld_wdata,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr
);

  always_comb begin
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_rd    = i_cpu_rd;
    o_mem_wr    = i_cpu_wr;
    if (i_ld_gnt) begin
      o_mem_addr  = i_ld_addr;
      o_mem_wdata = i_ld_wdata;
      o_mem_rd    = ~i_ld_we;
      o_mem_wr    = i_ld_we;
    end else if (i_strobe_block) begin
      o_mem_rd = 1'b0;
      o_mem_wr = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Phase sequencer for the accumulator CPU with run/step/halt control and
// instruction-boundary arbitration of the memory port for the loader.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CNTW   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_clr_halt,
  input  logic              i_halt_in,
  output logic [2:0]        o_phase,
  output logic              o_running,
  output logic              o_halted,
  output logic [CNTW-1:0]   o_instr_count,
  input  logic [AWIDTH-1:0] i_cpu_addr,
  input  logic [DWIDTH-1:0] i_cpu_wdata,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [AWIDTH-1:0] i_ld_addr,
  input  logic [DWIDTH-1:0] i_ld_wdata,
  output logic              o_ld_gnt,
  output logic              o_ld_done,
  output logic [DWIDTH-1:0] o_ld_rdata,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic [DWIDTH-1:0] i_mem_rdata
);

  seq_state_e        r_state, w_state_d;
  seq_state_e        r_ret, w_ret_d;
  logic [2:0]        r_phase, w_phase_d;
  logic [CNTW-1:0]   r_count, w_count_d;
  logic              r_ld_gnt;
  logic              r_ld_done;
  logic [DWIDTH-1:0] r_ld_rdata;

  always_comb begin
    w_state_d = r_state;
    w_ret_d   = r_ret;
    w_phase_d = r_phase;
    w_count_d = r_count;
    unique case (r_state)
      StIdle: begin
        w_phase_d = Phase0;
        if (i_ld_req) begin
          w_state_d = StLoad;
          w_ret_d   = StIdle;
        end else if (i_run) begin
          w_state_d = StRun;
        end else if (i_step) begin
          w_state_d = StStep;
        end
      end
      StRun, StStep: begin
        if (r_phase == PhaseHaltChk && i_halt_in) begin
          // Halting instruction is abandoned and does not retire
          w_state_d = StHalted;
          w_phase_d = Phase0;
        end else if (r_phase == PhaseLast) begin
          w_phase_d = Phase0;
          w_count_d = r_count + CNTW'(1);
          if (i_ld_req) begin
            w_state_d = StLoad;
            w_ret_d   = r_state;
          end else if (r_state == StStep || !i_run) begin
            w_state_d = StIdle;
          end
        end else begin
          w_phase_d = r_phase + 3'd1;
        end
      end
      StHalted: begin
        w_phase_d = Phase0;
        if (i_ld_req) begin
          w_state_d = StLoad;
          w_ret_d   = StHalted;
        end else if (i_clr_halt) begin
          w_state_d = StIdle;
        end
      end
      StLoad: begin
        w_state_d = StDone;
      end
      StDone: begin
        if (r_ret == StRun) begin
          w_state_d = i_run ? StRun : StIdle;
        end else if (r_ret == StHalted) begin
          w_state_d = StHalted;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_phase_d = Phase0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ret      <= StIdle;
      r_phase    <= Phase0;
      r_count    <= '0;
      r_ld_gnt   <= 1'b0;
      r_ld_done  <= 1'b0;
      r_ld_rdata <= '0;
    end else begin
      r_state   <= w_state_d;
      r_ret     <= w_ret_d;
      r_phase   <= w_phase_d;
      r_count   <= w_count_d;
      r_ld_gnt  <= (w_state_d == StLoad);
      r_ld_done <= (w_state_d == StDone);
      if (r_state == StLoad) begin
        r_ld_rdata <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_phase       = r_phase;
    o_running     = is_exec(r_state);
    o_halted      = (r_state == StHalted);
    o_instr_count = r_count;
    o_ld_gnt      = r_ld_gnt;
    o_ld_done     = r_ld_done;
    o_ld_rdata    = r_ld_rdata;
  end

  mem_port_mux #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_mem_port_mux (
    .i_ld_gnt      (r_ld_gnt),
    .i_strobe_block(r_ld_done),
    .i_cpu_addr    (i_cpu_addr),
    .i_cpu_wdata   (i_cpu_wdata),
    .i_cpu_rd      (i_cpu_rd),
    .i_cpu_wr      (i_cpu_wr),
    .i_ld_we       (i_ld_we),
    .i_ld_addr     (i_ld_addr),
    .i_ld_wdata    (i_ld_wdata),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_rd      (o_mem_rd),
    .o_mem_wr      (o_mem_wr)
  );

endmodule
